// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: architectural widths, the queue entry type and PC helpers.
package instruction_fetch_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instructions are word aligned; the low address bits of a target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous queue of {instr, pc} entries with flush; wrap-around pointers, Depth a power of two.
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic                push_i,
  input  fetch_entry_t        push_data_i,
  input  logic                pop_i,
  output fetch_entry_t        head_o,
  output logic [CntW-1:0]     count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  fetch_entry_t mem_q [Depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, one-deep in-flight tracking against a 1-cycle memory, credit-gated
// issue into an output queue toward decode, and redirect/flush handling.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

  logic            pop;
  logic            push;
  logic            issue;
  logic [OccW-1:0] occupancy;
  logic [CntW-1:0] count;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q && !redirect_valid;
  assign push_data = '{instr: imem_instr, pc: inflight_pc_q};

  // Entries queued plus the response still owed by memory, less the one leaving this edge.
  assign occupancy = OccW'(count) + OccW'(inflight_q) - OccW'(pop);
  assign issue     = !redirect_valid && (occupancy < OccW'(FIFO_DEPTH));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (issue) begin
      pc_d          = next_pc(pc_q);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign imem_addr = pc_q;
  assign out_pc    = head.pc;
  assign out_instr = out_valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios queue expected {pc, instr} pairs and
// a negedge monitor checks every accepted output against them.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC   (64'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // Big-endian memory image 11 22 33 44 AA BB CC DD FE DC BA 98; elsewhere a marked address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h1122_3344;
      64'd4:   return 32'hAABB_CCDD;
      64'd8:   return 32'hFEDC_BA98;
      default: return a[31:0] ^ 32'h5A5A_0000;
    endcase
  endfunction

  always @(posedge clk) imem_instr <= mem_word(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [63:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int n);
    out_ready = 1'b1;
    repeat (n) step();
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got pc %h instr %h, expected none", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", {32'h0, out_instr}, {32'h0, e.instr});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    // Reset state
    step();
    step();
    check("reset_addr", imem_addr, 64'h0);
    check("reset_valid", {63'h0, out_valid}, 64'h0);

    // Streaming with out_ready held high
    reset = 1'b0;
    expect_out(64'h0, 32'h1122_3344);
    expect_out(64'h4, 32'hAABB_CCDD);
    expect_out(64'h8, 32'hFEDC_BA98);
    out_ready = 1'b1;
    step();
    check("stream_valid_e0", {63'h0, out_valid}, 64'h0);
    step();
    check("stream_valid_e1", {63'h0, out_valid}, 64'h1);
    accept(3);

    // Back-pressure: queue fills, PC stalls, head stable
    reset = 1'b1;
    step();
    check("rst2_valid", {63'h0, out_valid}, 64'h0);
    reset = 1'b0;
    step();
    step();
    check("bp_valid_e1", {63'h0, out_valid}, 64'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("bp_addr_hold", imem_addr, 64'h8);
      check("bp_head_pc", out_pc, 64'h0);
      check("bp_head_instr", {32'h0, out_instr}, 64'h1122_3344);
    end
    expect_out(64'h0, 32'h1122_3344);
    expect_out(64'h4, 32'hAABB_CCDD);
    expect_out(64'h8, 32'hFEDC_BA98);
    accept(3);

    // Redirect to 9 while streaming; the coincident pop still completes
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_out(64'h0, 32'h1122_3344);
    expect_out(64'h4, 32'hAABB_CCDD);
    expect_out(64'h8, 32'hFEDC_BA98);
    out_ready = 1'b1;
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h9;
    step();
    redirect_valid = 1'b0;
    check("redir_valid_flush", {63'h0, out_valid}, 64'h0);
    check("redir_addr", imem_addr, 64'h8);
    step();
    check("redir_valid_e0", {63'h0, out_valid}, 64'h0);
    step();
    check("redir_valid_e1", {63'h0, out_valid}, 64'h1);
    step();
    out_ready = 1'b0;

    // Redirect with a full queue and out_ready low
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    step();
    step();
    check("full_addr_stall", imem_addr, 64'h8);
    check("full_valid", {63'h0, out_valid}, 64'h1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h23;
    step();
    redirect_valid = 1'b0;
    check("fullredir_valid", {63'h0, out_valid}, 64'h0);
    check("fullredir_addr", imem_addr, 64'h20);
    step();
    check("fullredir_valid_e0", {63'h0, out_valid}, 64'h0);
    step();
    check("fullredir_valid_e1", {63'h0, out_valid}, 64'h1);
    expect_out(64'h20, 32'h5A5A_0020);
    accept(1);

    // Reset mid-stream with a response in flight
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_out(64'h0, 32'h1122_3344);
    out_ready = 1'b1;
    step();
    step();
    step();
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    check("midrst_valid", {63'h0, out_valid}, 64'h0);
    check("midrst_addr", imem_addr, 64'h0);
    reset = 1'b0;
    expect_out(64'h0, 32'h1122_3344);
    step();
    check("midrst_valid_e0", {63'h0, out_valid}, 64'h0);
    step();
    check("midrst_valid_e1", {63'h0, out_valid}, 64'h1);
    accept(1);

    // Simultaneous reset and redirect: reset wins
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    step();
    check("rst_redir_addr", imem_addr, 64'h0);
    check("rst_redir_valid", {63'h0, out_valid}, 64'h0);
    step();
    check("rst_redir_addr2", imem_addr, 64'h0);
    redirect_valid = 1'b0;
    step();

    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
